// File: rtl/datapath_gen.sv
// datapath_gen: shared-bus multi-cycle CPU datapath with GPR file, PC/IR/MAR/MDR/Y/HI/LO, Z, ports and iterative signed MUL/DIV
// Define DATAPATH_GEN_DIV_EN to build the iterative divider; without it alu_op DIV is a no-op.
module datapath_gen #(
    parameter int WIDTH  = 32,
    parameter int NREGS  = 16,
    parameter int RAM_AW = 9
) (
    input  logic              clk,
    input  logic              clear,
    input  logic [3:0]        src_sel,
    input  logic [1:0]        gr_sel,
    input  logic              ba_out,
    input  logic [8:0]        dst_en,
    input  logic [3:0]        alu_op,
    input  logic              alu_start,
    output logic              alu_busy,
    output logic              alu_done,
    input  logic              mem_rd,
    input  logic              mem_wr,
    output logic [RAM_AW-1:0] mem_addr,
    output logic [WIDTH-1:0]  mem_wdata,
    input  logic [WIDTH-1:0]  mem_rdata,
    output logic              mem_we,
    input  logic [WIDTH-1:0]  inport_data,
    input  logic              inport_strobe,
    output logic [WIDTH-1:0]  outport_data,
    input  logic              con_en,
    output logic              con_ff,
    output logic [WIDTH-1:0]  bus,
    output logic [WIDTH-1:0]  pc_q,
    output logic [WIDTH-1:0]  ir_q
);
    localparam int RW = $clog2(NREGS);
    localparam int SW = $clog2(WIDTH);
    localparam int CW = WIDTH - 5 - 3 * RW;

    localparam logic [3:0] OP_AND   = 4'd0;
    localparam logic [3:0] OP_OR    = 4'd1;
    localparam logic [3:0] OP_ADD   = 4'd2;
    localparam logic [3:0] OP_SUB   = 4'd3;
    localparam logic [3:0] OP_MUL   = 4'd4;
    localparam logic [3:0] OP_DIV   = 4'd5;
    localparam logic [3:0] OP_SHR   = 4'd6;
    localparam logic [3:0] OP_SHRA  = 4'd7;
    localparam logic [3:0] OP_SHL   = 4'd8;
    localparam logic [3:0] OP_ROR   = 4'd9;
    localparam logic [3:0] OP_ROL   = 4'd10;
    localparam logic [3:0] OP_NEG   = 4'd11;
    localparam logic [3:0] OP_NOT   = 4'd12;
    localparam logic [3:0] OP_INCPC = 4'd13;

    typedef enum logic [1:0] {IDLE, ITER, FIX} state_t;

    logic [WIDTH-1:0]  gpr [NREGS];
    logic [WIDTH-1:0]  pc, ir, y, hi, lo, mdr, inport, zh, zl;
    logic [RAM_AW-1:0] mar;

    logic [RW-1:0]    ra, rb, rc, gidx;
    logic [1:0]       c2;
    logic [WIDTH-1:0] c_sext;

    assign ra     = ir[WIDTH-6 -: RW];
    assign rb     = ir[WIDTH-6-RW -: RW];
    assign rc     = ir[WIDTH-6-2*RW -: RW];
    assign c2     = ir[WIDTH-6-RW -: 2];
    assign c_sext = {{(WIDTH-CW){ir[CW-1]}}, ir[CW-1:0]};
    assign gidx   = gr_sel == 2'd1 ? rb : gr_sel == 2'd2 ? rc : ra;

    assign mem_addr     = mar;
    assign mem_wdata    = mdr;
    assign mem_we       = mem_wr;
    assign pc_q         = pc;
    assign ir_q         = ir;

    // Bus source multiplexer; unassigned codes drive zero
    always_comb begin
        bus = '0;
        case (src_sel)
            4'd1: bus = (ba_out && gidx == '0) ? '0 : gpr[gidx];
            4'd2: bus = hi;
            4'd3: bus = lo;
            4'd4: bus = zh;
            4'd5: bus = zl;
            4'd6: bus = pc;
            4'd7: bus = mdr;
            4'd8: bus = inport;
            4'd9: bus = c_sext;
            default: bus = '0;
        endcase
    end

    logic [SW-1:0]    sh;
    logic [SW:0]      shc;
    logic [WIDTH-1:0] res;
    logic             res_ok;

    assign sh  = bus[SW-1:0];
    assign shc = (SW+1)'(WIDTH) - {1'b0, sh};

    // Single-cycle ALU on A = Y and B = bus; res_ok flags ops that write Z at once
    always_comb begin
        res    = '0;
        res_ok = 1'b1;
        case (alu_op)
            OP_AND:   res = y & bus;
            OP_OR:    res = y | bus;
            OP_ADD:   res = y + bus;
            OP_SUB:   res = y - bus;
            OP_SHR:   res = y >> sh;
            OP_SHRA:  res = $signed(y) >>> sh;
            OP_SHL:   res = y << sh;
            OP_ROR:   res = (y >> sh) | (y << shc);
            OP_ROL:   res = (y << sh) | (y >> shc);
            OP_NEG:   res = '0 - bus;
            OP_NOT:   res = ~bus;
            OP_INCPC: res = bus + 1'b1;
            default:  res_ok = 1'b0;
        endcase
    end

    state_t           state;
    logic [SW-1:0]    cnt;
    logic [WIDTH-1:0] acc_hi, acc_lo, opnd, abs_a, abs_b;
    logic [WIDTH:0]   mul_sum;
    logic             neg_q, iter_op, is_mul;

    assign abs_a   = y[WIDTH-1] ? '0 - y : y;
    assign abs_b   = bus[WIDTH-1] ? '0 - bus : bus;
    assign is_mul  = alu_op == OP_MUL;
    assign mul_sum = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opnd} : {(WIDTH+1){1'b0}});

`ifdef DATAPATH_GEN_DIV_EN
    logic             is_div, sa_q, bz;
    logic [WIDTH-1:0] a_q, div_diff;
    logic [WIDTH:0]   div_sh;
    logic             div_ge;

    assign iter_op  = is_mul || alu_op == OP_DIV;
    assign div_sh   = {acc_hi, acc_lo[WIDTH-1]};
    assign div_ge   = div_sh >= {1'b0, opnd};
    assign div_diff = div_sh[WIDTH-1:0] - opnd;
`else
    assign iter_op  = is_mul;
`endif

    // Z register and the MUL/DIV sequencer: magnitudes shift for WIDTH cycles, then one sign-fix cycle
    always_ff @(posedge clk or negedge clear) begin
        if (!clear) begin
            state    <= IDLE;
            alu_busy <= 1'b0;
            alu_done <= 1'b0;
            zh       <= '0;
            zl       <= '0;
            cnt      <= '0;
            acc_hi   <= '0;
            acc_lo   <= '0;
            opnd     <= '0;
            neg_q    <= 1'b0;
`ifdef DATAPATH_GEN_DIV_EN
            is_div   <= 1'b0;
            sa_q     <= 1'b0;
            bz       <= 1'b0;
            a_q      <= '0;
`endif
        end else begin
            alu_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (alu_start && iter_op) begin
                        opnd     <= is_mul ? abs_a : abs_b;
                        acc_lo   <= is_mul ? abs_b : abs_a;
                        acc_hi   <= '0;
                        neg_q    <= y[WIDTH-1] ^ bus[WIDTH-1];
                        cnt      <= '0;
                        alu_busy <= 1'b1;
                        state    <= ITER;
`ifdef DATAPATH_GEN_DIV_EN
                        is_div   <= !is_mul;
                        sa_q     <= y[WIDTH-1];
                        bz       <= bus == '0;
                        a_q      <= y;
`endif
                    end else if (alu_start && res_ok) begin
                        zh <= '0;
                        zl <= res;
                    end
                end
                ITER: begin
`ifdef DATAPATH_GEN_DIV_EN
                    if (is_div) begin
                        acc_hi <= div_ge ? div_diff : div_sh[WIDTH-1:0];
                        acc_lo <= {acc_lo[WIDTH-2:0], div_ge};
                    end else
`endif
                    {acc_hi, acc_lo} <= {mul_sum, acc_lo[WIDTH-1:1]};
                    cnt <= cnt + 1'b1;
                    if (cnt == SW'(WIDTH-1))
                        state <= FIX;
                end
                default: begin
`ifdef DATAPATH_GEN_DIV_EN
                    if (is_div) begin
                        zl <= bz ? '1 : (neg_q ? '0 - acc_lo : acc_lo);
                        zh <= bz ? a_q : (sa_q ? '0 - acc_hi : acc_hi);
                    end else
`endif
                    {zh, zl} <= neg_q ? '0 - {acc_hi, acc_lo} : {acc_hi, acc_lo};
                    alu_busy <= 1'b0;
                    alu_done <= 1'b1;
                    state    <= IDLE;
                end
            endcase
        end
    end

    // Bus-loaded architectural registers, I/O ports and the branch-condition flop
    always_ff @(posedge clk or negedge clear) begin
        if (!clear) begin
            for (int i = 0; i < NREGS; i++)
                gpr[i] <= '0;
            pc           <= '0;
            ir           <= '0;
            mar          <= '0;
            y            <= '0;
            hi           <= '0;
            lo           <= '0;
            mdr          <= '0;
            inport       <= '0;
            outport_data <= '0;
            con_ff       <= 1'b0;
        end else begin
            if (dst_en[0]) gpr[gidx] <= bus;
            if (dst_en[1]) pc <= bus;
            if (dst_en[2]) ir <= bus;
            if (dst_en[3]) mar <= bus[RAM_AW-1:0];
            if (dst_en[4]) y <= bus;
            if (dst_en[5]) hi <= bus;
            if (dst_en[6]) lo <= bus;
            if (dst_en[7]) mdr <= mem_rd ? mem_rdata : bus;
            if (dst_en[8]) outport_data <= bus;
            if (inport_strobe) inport <= inport_data;
            if (con_en)
                con_ff <= c2 == 2'd0 ? bus == '0 :
                          c2 == 2'd1 ? bus != '0 :
                          c2 == 2'd2 ? !bus[WIDTH-1] : bus[WIDTH-1];
        end
    end
endmodule
